fcmp_arb: RTL and testbench

Two-requester arbiter and 2-stage pipeline wrapped around the FPU's single-precision compare datapath. It lets the integer-side and FPU-side issue ports share one comparator for feq/flt/fle/fge. Requests are granted round-robin with valid/ready handshakes. Operands are registered, the 1-bit result is computed and registered, and the result is returned with the requester id and destination tag.

---
 rtl/fcmp_arb_if.sv | 43 ++++
 rtl/fcmp_arb.sv | 116 +++++++++++
 tb/tb_fcmp_arb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fcmp_arb_if.sv
// fcmp_arb_if: request/response bundle for the shared FP compare unit.
// master = requesters + result consumer, slave = the arbiter/pipeline.
interface fcmp_arb_if #(
  parameter int TAG_W = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [31:0]      req0_x1;
  logic [31:0]      req0_x2;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [31:0]      req1_x1;
  logic [31:0]      req1_x2;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_y;

  modport master (
    output req0_valid, req0_op, req0_x1, req0_x2, req0_tag,
    input  req0_ready,
    output req1_valid, req1_op, req1_x1, req1_x2, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_tag, rsp_y,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_x1, req0_x2, req0_tag,
    output req0_ready,
    input  req1_valid, req1_op, req1_x1, req1_x2, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_tag, rsp_y,
    input  rsp_ready
  );
endinterface

// File: rtl/fcmp_arb.sv
// fcmp_arb: two-requester round-robin arbiter in front of a 2-stage
// single-precision compare pipeline (feq/flt/fle/fge).
// S1 registers the granted request, S2 registers the 1-bit result.
// Optional: define FCMP_ZERO_EQ_EN to make +0 and -0 compare equal;
// otherwise operands are ordered purely by bit pattern (+0 > -0).
module fcmp_arb #(
  parameter int TAG_W = 5
) (
  input logic        clk,
  input logic        rst,
  fcmp_arb_if.slave  bus
);
  typedef struct packed {
    logic [1:0]       op;
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
    logic             id;
  } s1_t;

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  s1_t              s1;
  s1_t [1:0]        req_d;
  s1_t              req_sel;
  logic             s1_v, s2_v, rr_last;
  logic             s2_free, s1_free, gnt0, gnt1;
  logic             y_c;
  logic             s2_y, s2_id;
  logic [TAG_W-1:0] s2_tag;

  // a >= b over sign-magnitude fields; sign bits decide mixed-sign cases
  function automatic logic ge(input logic [31:0] a, input logic [31:0] b);
    logic r;
    case ({a[31], b[31]})
      2'b00:   r = (a[30:0] >= b[30:0]);
      2'b01:   r = 1'b1;
      2'b10:   r = 1'b0;
      default: r = (a[30:0] <= b[30:0]);
    endcase
`ifdef FCMP_ZERO_EQ_EN
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) r = 1'b1;
`endif
    return r;
  endfunction

  assign req_d[0] = '{op: bus.req0_op, x1: bus.req0_x1, x2: bus.req0_x2,
                      tag: bus.req0_tag, id: 1'b0};
  assign req_d[1] = '{op: bus.req1_op, x1: bus.req1_x1, x2: bus.req1_x2,
                      tag: bus.req1_tag, id: 1'b1};

  // handshake/flow control: ready never depends on request payload
  always_comb begin
    s2_free = !s2_v || bus.rsp_ready;
    s1_free = !s1_v || s2_free;
    gnt0    = s1_free && bus.req0_valid && (!bus.req1_valid || rr_last);
    gnt1    = s1_free && bus.req1_valid && (!bus.req0_valid || !rr_last);
    req_sel = gnt1 ? req_d[1] : req_d[0];
  end

  assign bus.req0_ready = gnt0 && !rst;
  assign bus.req1_ready = gnt1 && !rst;

  // compare core between S1 and S2
  always_comb begin
    y_c = 1'b0;
    case (s1.op)
      OP_FEQ:  y_c = ge(s1.x1, s1.x2) && ge(s1.x2, s1.x1);
      OP_FLT:  y_c = !ge(s1.x1, s1.x2);
      OP_FLE:  y_c = ge(s1.x2, s1.x1);
      default: y_c = ge(s1.x1, s1.x2);
    endcase
  end

  // S1: load the granted request; empties when its content moves on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1   <= '0;
    end else if (s1_free) begin
      s1_v <= gnt0 || gnt1;
      if (gnt0 || gnt1) s1 <= req_sel;
    end
  end

  // round-robin pointer: remembers the last granted requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_last <= 1'b1;
    else if (gnt0) rr_last <= 1'b0;
    else if (gnt1) rr_last <= 1'b1;
  end

  // S2: result register; holds while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      s2_y   <= 1'b0;
      s2_id  <= 1'b0;
      s2_tag <= '0;
    end else if (s2_free) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_y   <= y_c;
        s2_id  <= s1.id;
        s2_tag <= s1.tag;
      end
    end
  end

  assign bus.rsp_valid = s2_v;
  assign bus.rsp_y     = s2_y;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_tag   = s2_tag;
endmodule

// File: tb/tb_fcmp_arb.sv
// tb_fcmp_arb: directed stimulus for fcmp_arb with a queue-based reference
// model checked every negedge, plus literal expectations on key points.
module tb_fcmp_arb;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcmp_arb_if #(.TAG_W(TAG_W)) bus ();
  fcmp_arb #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Map each float to an integer key whose ordering is the required one:
  // negatives map below all non-negatives, -0 sits just below +0.
  function automatic longint fkey(input logic [31:0] a);
    longint mag;
    mag = longint'({33'd0, a[30:0]});
    return a[31] ? (-mag - 1) : mag;
  endfunction

  function automatic logic mge(input logic [31:0] a, input logic [31:0] b);
`ifdef FCMP_ZERO_EQ_EN
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b1;
`endif
    return fkey(a) >= fkey(b);
  endfunction

  function automatic logic mres(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return mge(a, b) && mge(b, a);
      2'b01:   return !mge(a, b);
      2'b10:   return mge(b, a);
      default: return mge(a, b);
    endcase
  endfunction

  typedef struct {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic             y;
  } ent_t;

  ent_t q[$];
  logic last = 1'b1;

  // compare process: the queue holds every accepted, not yet consumed op
  always @(negedge clk) begin
    logic can, e0, e1;
    ent_t e;
    if (rst) begin
      q.delete();
      last = 1'b1;
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
    end else begin
      can = (q.size() < 2) || bus.rsp_ready;
      e0 = can && bus.req0_valid && (!bus.req1_valid || last);
      e1 = can && bus.req1_valid && (!bus.req0_valid || !last);
      chk("m_ready0", bus.req0_ready, e0);
      chk("m_ready1", bus.req1_ready, e1);
      if (bus.rsp_valid) begin
        if (q.size() == 0) chk("m_stale_rsp", 1, 0);
        else begin
          chk("m_rsp_id", bus.rsp_id, q[0].id);
          chk("m_rsp_tag", bus.rsp_tag, q[0].tag);
          chk("m_rsp_y", bus.rsp_y, q[0].y);
          if (bus.rsp_ready) void'(q.pop_front());
        end
      end
      if (e0) begin
        e.id = 1'b0; e.tag = bus.req0_tag;
        e.y = mres(bus.req0_op, bus.req0_x1, bus.req0_x2);
        q.push_back(e); last = 1'b0;
      end else if (e1) begin
        e.id = 1'b1; e.tag = bus.req1_tag;
        e.y = mres(bus.req1_op, bus.req1_x1, bus.req1_x2);
        q.push_back(e); last = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_x1 = a; bus.req0_x2 = b; bus.req0_tag = t;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_x1 = a; bus.req1_x2 = b; bus.req1_tag = t;
    end
  endtask

  // one isolated request with literal latency/result expectations
  task automatic single(input string name, input int r, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input logic exp_y);
    step();
    set_req(r, 1'b1, op, a, b, t);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk({name, "_ready"}, (r == 0) ? bus.req0_ready : bus.req1_ready, 1);
    step();
    set_req(r, 1'b0, op, a, b, t);
    @(negedge clk);
    chk({name, "_early"}, bus.rsp_valid, 0);
    step();
    @(negedge clk);
    chk({name, "_valid"}, bus.rsp_valid, 1);
    chk({name, "_y"}, bus.rsp_y, exp_y);
    chk({name, "_id"}, bus.rsp_id, r);
    chk({name, "_tag"}, bus.rsp_tag, t);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int ngr;
    logic zexp;
    set_req(0, 1'b1, 2'b00, 32'h0, 32'h0, 5'd0);
    set_req(1, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    bus.rsp_ready = 1'b1;

    // reset state
    repeat (3) step();
    chk("rst_y", bus.rsp_y, 0);
    chk("rst_tag", bus.rsp_tag, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_hold_ready0", bus.req0_ready, 0);
    set_req(0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    rst = 1'b0;

    // pipeline latency and op coverage
    single("fge_2_1", 0, 2'b11, 32'h40000000, 32'h3F800000, 5'd3, 1'b1);
    single("flt_m1_m2", 0, 2'b01, 32'hBF800000, 32'hC0000000, 5'd4, 1'b0);
    single("feq_m2", 0, 2'b00, 32'hC0000000, 32'hC0000000, 5'd5, 1'b1);
    single("flt_m2", 1, 2'b01, 32'hC0000000, 32'hC0000000, 5'd6, 1'b0);
    single("fle_m2", 0, 2'b10, 32'hC0000000, 32'hC0000000, 5'd7, 1'b1);
    single("fge_m2", 1, 2'b11, 32'hC0000000, 32'hC0000000, 5'd8, 1'b1);
    single("feq_1_m1", 0, 2'b00, 32'h3F800000, 32'hBF800000, 5'd9, 1'b0);
    single("flt_1_m1", 1, 2'b01, 32'h3F800000, 32'hBF800000, 5'd10, 1'b0);
    single("fge_1_m1", 0, 2'b11, 32'h3F800000, 32'hBF800000, 5'd11, 1'b1);
`ifdef FCMP_ZERO_EQ_EN
    zexp = 1'b1;
`else
    zexp = 1'b0;
`endif
    single("feq_pz_nz", 0, 2'b00, 32'h00000000, 32'h80000000, 5'd12, zexp);
    single("flt_nz_pz", 1, 2'b01, 32'h80000000, 32'h00000000, 5'd13, !zexp);

    // tie arbitration, last grant went to requester 1
    step();
    set_req(0, 1'b1, 2'b11, 32'hC0000000, 32'hC0000000, 5'd10);
    set_req(1, 1'b1, 2'b01, 32'h3F800000, 32'hBF800000, 5'd20);
    @(negedge clk);
    chk("tie_g0_r0", bus.req0_ready, 1);
    chk("tie_g0_r1", bus.req1_ready, 0);
    step();
    @(negedge clk);
    chk("tie_g1_r0", bus.req0_ready, 0);
    chk("tie_g1_r1", bus.req1_ready, 1);
    step();
    @(negedge clk);
    chk("tie_rsp0_id", bus.rsp_id, 0);
    step();
    @(negedge clk);
    chk("tie_rsp1_id", bus.rsp_id, 1);
    repeat (5) step();
    set_req(0, 1'b0, 2'b11, 32'hC0000000, 32'hC0000000, 5'd10);
    set_req(1, 1'b0, 2'b01, 32'h3F800000, 32'hBF800000, 5'd20);
    repeat (4) step();

    // backpressure from an empty pipeline: two accepts, then stall
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 2'b10, 32'h40000000, 32'h40400000, 5'd1);
    set_req(1, 1'b1, 2'b00, 32'h40400000, 32'h40400000, 5'd2);
    ngr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) ngr++;
      step();
    end
    chk("bp_grants", ngr, 2);
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 2'b10, 32'h40000000, 32'h40400000, 5'd1);
    set_req(1, 1'b0, 2'b00, 32'h40400000, 32'h40400000, 5'd2);
    repeat (4) step();
    @(negedge clk);
    chk("bp_drained", bus.rsp_valid, 0);

    // reset with both stages full
    step();
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 2'b11, 32'h1, 32'h2, 5'd17);
    set_req(1, 1'b1, 2'b11, 32'h3, 32'h2, 5'd18);
    repeat (3) step();
    chk("pre_rst_valid", bus.rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_ready0", bus.req0_ready, 0);
    chk("mid_rst_ready1", bus.req1_ready, 0);
    set_req(0, 1'b0, 2'b11, 32'h1, 32'h2, 5'd17);
    set_req(1, 1'b0, 2'b11, 32'h3, 32'h2, 5'd18);
    repeat (2) step();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", bus.rsp_valid, 0);
      step();
    end
    set_req(0, 1'b1, 2'b00, 32'h5, 32'h5, 5'd21);
    set_req(1, 1'b1, 2'b00, 32'h6, 32'h6, 5'd22);
    @(negedge clk);
    chk("post_rst_tie_r0", bus.req0_ready, 1);
    chk("post_rst_tie_r1", bus.req1_ready, 0);
    step();
    set_req(0, 1'b0, 2'b00, 32'h5, 32'h5, 5'd21);
    set_req(1, 1'b0, 2'b00, 32'h6, 32'h6, 5'd22);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
